// File: rtl/reaction_ctrl.sv
// Reaction-timer control FSM: debounces Start/React, sequences the datapath state bus
// and flags false starts and timeouts. Define REACTION_ROUNDS_EN to add the `rounds` counter.
`timescale 1ns/1ps

module reaction_ctrl #(
  parameter int DEBOUNCE_MS = 10,
  parameter int TIMEOUT_MS  = 999,
  parameter int DISPLAY_MS  = 5000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start_n,
  input  logic       React_n,
  input  logic       flag,
  output logic [1:0] state,
  output logic       false_start,
  output logic       timeout
`ifdef REACTION_ROUNDS_EN
  ,
  output logic [7:0] rounds
`endif
);

  localparam int              DBW       = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [DBW-1:0]  DB_LAST   = DBW'(DEBOUNCE_MS - 1);
  localparam logic [9:0]      T_LAST    = 10'(TIMEOUT_MS - 1);
  localparam logic [15:0]     D_LAST    = 16'(DISPLAY_MS - 1);
  localparam bit              DISP_AUTO = (DISPLAY_MS != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DELAY   = 2'd1,
    S_TIMING  = 2'd2,
    S_DISPLAY = 2'd3
  } state_t;

  // Bit 0 is Start, bit 1 is React; both are active-high "pressed" after inversion.
  logic [1:0] raw_press;
  logic [1:0] press_evt;

  assign raw_press = {~React_n, ~Start_n};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic           sync1_q;
      logic           sync2_q;
      logic           deb_q;
      logic           deb_d;
      logic [DBW-1:0] cnt_q;
      logic [DBW-1:0] cnt_d;
      logic           evt_q;

      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
          if (cnt_q == DB_LAST) begin
            deb_d = sync2_q;
          end else begin
            cnt_d = cnt_q + DBW'(1);
          end
        end
      end

      always_ff @(posedge Clock) begin
        if (!Resetn) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          deb_q   <= 1'b0;
          cnt_q   <= '0;
          evt_q   <= 1'b0;
        end else begin
          sync1_q <= raw_press[gi];
          sync2_q <= sync1_q;
          deb_q   <= deb_d;
          cnt_q   <= cnt_d;
          // Pulse on the same edge the debounced value rises, so the FSM sees it one edge later.
          evt_q   <= deb_d & ~deb_q;
        end
      end

      assign press_evt[gi] = evt_q;
    end
  endgenerate

  logic start_evt;
  logic react_evt;

  assign start_evt = press_evt[0];
  assign react_evt = press_evt[1];

  state_t      state_q;
  logic [9:0]  t_cnt_q;
  logic [15:0] hold_q;
  logic        false_start_q;
  logic        timeout_q;
`ifdef REACTION_ROUNDS_EN
  logic [7:0]  rounds_q;
`endif

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q       <= S_IDLE;
      t_cnt_q       <= '0;
      hold_q        <= '0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef REACTION_ROUNDS_EN
      rounds_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_evt) begin
            state_q       <= S_DELAY;
            false_start_q <= 1'b0;
            timeout_q     <= 1'b0;
          end
        end
        S_DELAY: begin
          // React beats flag: a press during the random delay is always a false start.
          if (react_evt) begin
            state_q       <= S_DISPLAY;
            false_start_q <= 1'b1;
            hold_q        <= '0;
          end else if (flag) begin
            state_q <= S_TIMING;
            t_cnt_q <= '0;
          end
        end
        S_TIMING: begin
          t_cnt_q <= t_cnt_q + 10'd1;
          if (react_evt) begin
            state_q <= S_DISPLAY;
            hold_q  <= '0;
`ifdef REACTION_ROUNDS_EN
            if (rounds_q != 8'hFF) begin
              rounds_q <= rounds_q + 8'd1;
            end
`endif
          end else if (t_cnt_q == T_LAST) begin
            state_q   <= S_DISPLAY;
            timeout_q <= 1'b1;
            hold_q    <= '0;
          end
        end
        S_DISPLAY: begin
          hold_q <= hold_q + 16'd1;
          if (start_evt) begin
            state_q <= S_IDLE;
          end else if (DISP_AUTO && (hold_q == D_LAST)) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign false_start = false_start_q;
  assign timeout     = timeout_q;
`ifdef REACTION_ROUNDS_EN
  assign rounds      = rounds_q;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: two instances (auto-return display and hold-until-Start display)
// driven by directed and random stimulus, compared every cycle against a behavioural model.
`timescale 1ns/1ps

module tb_reaction_ctrl;

  localparam int DEB    = 4;
  localparam int TO_A   = 20;
  localparam int DISP_A = 50;
  localparam int TO_B   = 300;
  localparam int DISP_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Resetn  = 1'b0;
  logic       Start_n = 1'b1;
  logic       React_n = 1'b1;
  logic       flag    = 1'b0;
  logic [1:0] state_a, state_b;
  logic       fs_a, fs_b, to_a, to_b;
`ifdef REACTION_ROUNDS_EN
  logic [7:0] rounds_a, rounds_b;
`endif

  reaction_ctrl #(.DEBOUNCE_MS(DEB), .TIMEOUT_MS(TO_A), .DISPLAY_MS(DISP_A)) u_dut_a (
    .Clock(clk), .Resetn(Resetn), .Start_n(Start_n), .React_n(React_n), .flag(flag),
    .state(state_a), .false_start(fs_a), .timeout(to_a)
`ifdef REACTION_ROUNDS_EN
    , .rounds(rounds_a)
`endif
  );

  reaction_ctrl #(.DEBOUNCE_MS(DEB), .TIMEOUT_MS(TO_B), .DISPLAY_MS(DISP_B)) u_dut_b (
    .Clock(clk), .Resetn(Resetn), .Start_n(Start_n), .React_n(React_n), .flag(flag),
    .state(state_b), .false_start(fs_b), .timeout(to_b)
`ifdef REACTION_ROUNDS_EN
    , .rounds(rounds_b)
`endif
  );

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: raw samples reach the debouncer two edges late; a change is accepted
  // once it has disagreed with the accepted value for DEB consecutive samples.
  bit [1:0] smp_q[$];
  bit [1:0] old_smp;
  bit       m_deb [2];
  int       m_run [2];
  bit       m_evt [2];
  bit       se, re;
  int       m_st [2];
  int       m_fs [2];
  int       m_to [2];
  int       m_n  [2];
  int       m_rounds [2];
  int       m_tlim [2] = '{TO_A, TO_B};
  int       m_dlim [2] = '{DISP_A, DISP_B};
  bit       chk_en = 1'b0;

  always @(posedge clk) begin
    if (!Resetn) begin
      smp_q.delete();
      smp_q.push_back(2'b00);
      smp_q.push_back(2'b00);
      for (int b = 0; b < 2; b++) begin
        m_deb[b] = 1'b0; m_run[b] = 0; m_evt[b] = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_fs[k] = 0; m_to[k] = 0; m_n[k] = 0; m_rounds[k] = 0;
      end
      chk_en = 1'b1;
    end else begin
      se = m_evt[0];
      re = m_evt[1];
      for (int k = 0; k < 2; k++) begin
        case (m_st[k])
          0: if (se) begin m_st[k] = 1; m_fs[k] = 0; m_to[k] = 0; end
          1: begin
            if (re) begin m_st[k] = 3; m_fs[k] = 1; m_n[k] = 0; end
            else if (flag) begin m_st[k] = 2; m_n[k] = 0; end
          end
          2: begin
            m_n[k]++;
            if (re) begin
              m_st[k] = 3; m_n[k] = 0;
              if (m_rounds[k] < 255) m_rounds[k]++;
            end else if (m_n[k] == m_tlim[k]) begin
              m_st[k] = 3; m_to[k] = 1; m_n[k] = 0;
            end
          end
          default: begin
            m_n[k]++;
            if (se) m_st[k] = 0;
            else if (m_dlim[k] != 0 && m_n[k] == m_dlim[k]) m_st[k] = 0;
          end
        endcase
      end
      old_smp = smp_q.pop_front();
      smp_q.push_back({~React_n, ~Start_n});
      for (int b = 0; b < 2; b++) begin
        m_evt[b] = 1'b0;
        if (old_smp[b] != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_deb[b] = old_smp[b];
            m_run[b] = 0;
            m_evt[b] = old_smp[b];
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state_a", 32'(state_a), m_st[0]);
      check("state_b", 32'(state_b), m_st[1]);
      check("false_start_a", 32'(fs_a), m_fs[0]);
      check("false_start_b", 32'(fs_b), m_fs[1]);
      check("timeout_a", 32'(to_a), m_to[0]);
      check("timeout_b", 32'(to_b), m_to[1]);
`ifdef REACTION_ROUNDS_EN
      check("rounds_a", 32'(rounds_a), m_rounds[0]);
      check("rounds_b", 32'(rounds_b), m_rounds[1]);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start(input int hold);
    Start_n = 1'b0;
    cyc(hold);
    Start_n = 1'b1;
  endtask

  task automatic pulse_flag();
    flag = 1'b1;
    cyc(1);
    flag = 1'b0;
  endtask

  int lat, na, nb, nda;
  int s_left, r_left;

  initial begin
    // Reset
    cyc(2);
    check("rst_state_a", 32'(state_a), 0);
    check("rst_state_b", 32'(state_b), 0);
    check("rst_flags_a", {30'd0, fs_a, to_a}, 0);
    Resetn = 1'b1;

    // Bounce: 3 low / 1 high never reaches DEB stable samples
    repeat (5) begin
      Start_n = 1'b0; cyc(3);
      Start_n = 1'b1; cyc(1);
    end
    cyc(12);
    check("bounce_a", 32'(state_a), 0);
    check("bounce_b", 32'(state_b), 0);

    // Start latency: DEB+3 posedges from first sampling edge
    Start_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (state_a == 2'd1) begin lat = i; break; end
    end
    @(negedge clk);
    check("start_latency", lat, DEB + 3);
    check("start_b", 32'(state_b), 1);
    cyc(3); Start_n = 1'b1; cyc(5);

    // Both enter TIMING; A times out, B gets a React after 250 cycles
    pulse_flag();
    check("enter_timing_a", 32'(state_a), 2);
    check("enter_timing_b", 32'(state_b), 2);
    na = 0; nb = 0; nda = 0;
    for (int i = 1; i <= 260; i++) begin
      if (state_a == 2'd2) na++;
      if (state_a == 2'd3) nda++;
      if (state_b == 2'd2) nb++;
      if (i == TO_A + 1) begin
        check("timeout_state_a", 32'(state_a), 3);
        check("timeout_flag_a", 32'(to_a), 1);
      end
      if (i == 244) React_n = 1'b0;
      if (i == 252) React_n = 1'b1;
      @(negedge clk);
    end
    check("timeout_dwell_a", na, TO_A);
    check("display_dwell_a", nda, DISP_A);
    check("react_dwell_b", nb, 250);
    check("react_state_b", 32'(state_b), 3);
    check("react_flags_b", {30'd0, fs_b, to_b}, 0);
`ifdef REACTION_ROUNDS_EN
    check("rounds_after_react_b", 32'(rounds_b), 1);
`endif

    // DISPLAY_MS=0 holds until Start
    cyc(10000);
    check("hold_b", 32'(state_b), 3);
    press_start(8); cyc(6);
    check("start_a_delay", 32'(state_a), 1);
    check("start_b_idle", 32'(state_b), 0);
    check("cleared_to_a", 32'(to_a), 0);
    press_start(8); cyc(6);
    check("start_ignored_a", 32'(state_a), 1);
    check("start_b_delay", 32'(state_b), 1);

    // False start with flag low
    React_n = 1'b0; cyc(8); React_n = 1'b1; cyc(4);
    check("fs_state_a", 32'(state_a), 3);
    check("fs_flag_a", 32'(fs_a), 1);
    check("fs_flag_b", 32'(fs_b), 1);
    cyc(60);
    press_start(8); cyc(6);
    press_start(8); cyc(6);

    // React event and flag on the same edge: react wins
    React_n = 1'b0; cyc(6);
    flag = 1'b1; cyc(1); flag = 1'b0;
    check("race_state_a", 32'(state_a), 3);
    check("race_state_b", 32'(state_b), 3);
    check("race_fs_a", 32'(fs_a), 1);
    React_n = 1'b1;
    cyc(60);

    // Reset, then reset in the middle of TIMING
    Resetn = 1'b0; cyc(1);
    check("rst2_state_b", 32'(state_b), 0);
    Resetn = 1'b1;
    press_start(8); cyc(4);
    pulse_flag();
    check("timing2_a", 32'(state_a), 2);
    cyc(5);
    Resetn = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_a", 32'(state_a), 0);
    check("rst_mid_b", 32'(state_b), 0);
    @(negedge clk);
    Resetn = 1'b1;

    // Timeout flag survives IDLE and clears on the next IDLE->DELAY
    press_start(8); cyc(4);
    pulse_flag();
    cyc(25);
    check("to2_state_a", 32'(state_a), 3);
    check("to2_flag_a", 32'(to_a), 1);
    press_start(8); cyc(6);
    check("to2_idle_a", 32'(state_a), 0);
    check("to2_held_a", 32'(to_a), 1);
    press_start(8); cyc(6);
    check("to2_delay_a", 32'(state_a), 1);
    check("to2_cleared_a", {30'd0, fs_a, to_a}, 0);
    check("to2_timing_b", 32'(state_b), 2);

    // Random phase
    s_left = 0; r_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (s_left == 0) begin
        Start_n = 1'($urandom_range(0, 1));
        s_left  = $urandom_range(1, 14);
      end
      if (r_left == 0) begin
        React_n = 1'($urandom_range(0, 1));
        r_left  = $urandom_range(1, 14);
      end
      s_left--; r_left--;
      flag   = ($urandom_range(0, 7) == 0);
      Resetn = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    Resetn = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
